// File: rtl/obuf_data_unshuffler.sv
// ============================================================================
//  Module      : obuf_data_unshuffler
//  Description : Re-interleaves bank-grouped output-buffer beats into DDR word
//                order through a 2-entry skid FIFO, one burst at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obuf_data_unshuffler #(
   parameter int DDR_BANDWIDTH = 512,
   parameter int NUM_BANKS     = 8,
   parameter int DATA_WIDTH    = 8,
   parameter int BEAT_CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [BEAT_CNT_W-1:0]    num_beats,
   output logic                     busy,
   output logic                     done,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DDR_BANDWIDTH-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DDR_BANDWIDTH-1:0] out_data,
   output logic                     out_last
);

   localparam int RATIO = DDR_BANDWIDTH / (NUM_BANKS * DATA_WIDTH);
   localparam logic [BEAT_CNT_W-1:0] CNT_ONE = {{(BEAT_CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [BEAT_CNT_W-1:0]    num_beats_q, num_beats_d;
   logic [BEAT_CNT_W-1:0]    in_cnt_q, in_cnt_d;
   logic [BEAT_CNT_W-1:0]    out_cnt_q, out_cnt_d;
   logic [DDR_BANDWIDTH-1:0] fifo_data_q [2];
   logic [DDR_BANDWIDTH-1:0] fifo_data_d [2];
   logic                     fifo_last_q [2];
   logic                     fifo_last_d [2];
   logic                     wr_ptr_q, wr_ptr_d;
   logic                     rd_ptr_q, rd_ptr_d;
   logic [1:0]               fifo_count_q, fifo_count_d;

   logic [DDR_BANDWIDTH-1:0] perm_data;
   logic                     push;
   logic                     pop;
   logic                     push_last;

   // Element i of bank j moves to DDR lane i*NUM_BANKS + j.
   for (genvar j = 0; j < NUM_BANKS; j++) begin : g_bank
      for (genvar i = 0; i < RATIO; i++) begin : g_elem
         assign perm_data[(i*NUM_BANKS+j)*DATA_WIDTH +: DATA_WIDTH] =
            in_data[(j*RATIO+i)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign in_ready  = (state_q == ST_ACTIVE) && (fifo_count_q < 2'd2) &&
                      (in_cnt_q < num_beats_q);
   assign out_valid = (fifo_count_q != 2'd0);
   assign out_data  = fifo_data_q[rd_ptr_q];
   assign out_last  = fifo_last_q[rd_ptr_q];
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);

   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign push_last = (in_cnt_q == num_beats_q - CNT_ONE);

   always_comb begin
      state_d      = state_q;
      num_beats_d  = num_beats_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      fifo_data_d  = fifo_data_q;
      fifo_last_d  = fifo_last_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fifo_count_d = fifo_count_q;

      if (push) begin
         fifo_data_d[wr_ptr_q] = perm_data;
         fifo_last_d[wr_ptr_q] = push_last;
         wr_ptr_d              = ~wr_ptr_q;
         in_cnt_d              = in_cnt_q + CNT_ONE;
      end
      if (pop) begin
         rd_ptr_d  = ~rd_ptr_q;
         out_cnt_d = out_cnt_q + CNT_ONE;
      end
      case ({push, pop})
         2'b10:   fifo_count_d = fifo_count_q + 2'd1;
         2'b01:   fifo_count_d = fifo_count_q - 2'd1;
         default: fifo_count_d = fifo_count_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_beats != '0) begin
                  num_beats_d = num_beats;
                  in_cnt_d    = '0;
                  out_cnt_d   = '0;
                  state_d     = ST_ACTIVE;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_ACTIVE: begin
            if (push && push_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Uses the post-pop count so done follows the last handshake by one cycle.
            if (out_cnt_d == num_beats_q) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         num_beats_q    <= '0;
         in_cnt_q       <= '0;
         out_cnt_q      <= '0;
         fifo_data_q[0] <= '0;
         fifo_data_q[1] <= '0;
         fifo_last_q[0] <= 1'b0;
         fifo_last_q[1] <= 1'b0;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         fifo_count_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         num_beats_q  <= num_beats_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         fifo_data_q  <= fifo_data_d;
         fifo_last_q  <= fifo_last_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_count_q <= fifo_count_d;
      end
   end

endmodule

`default_nettype wire
